modinv_check: RTL and testbench
===============================

MODINV_CHECK -- requirements
Module: modinv_check

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start_compute, input, 1 bit: level request.
- Sampled only in IDLE.
- Must stay high until done is seen.
REQ-004 SHALL have port e, input, 64 bits: public exponent, unsigned.
REQ-005 SHALL have port phi, input, 64 bits: modulus, unsigned.
REQ-006 SHALL have port d, input, 64 bits: candidate inverse, as produced by the key-generation loop.
REQ-007 SHALL have port product, output, 64 bits: (e*d) mod phi.
REQ-008 SHALL have port valid, output, 1 bit: high when product==1 and err==0.
REQ-009 SHALL have port err, output, 1 bit: operand range violation.
REQ-010 SHALL have port busy, output, 1 bit: high in NORM and MULT.
REQ-011 SHALL have port done, output, 1 bit: result ready; held high while in END.

Function
REQ-012 SHALL implement states IDLE, NORM, MULT and END.
REQ-013 IDLE SHALL move to NORM on the edge that samples start_compute=1.
- On that edge e, phi and d are latched.
- On that edge product, valid and err are cleared.
REQ-014 NORM SHALL last one cycle and perform three steps:
- Normalize d (see REQ-024).
- Flag err if phi<2, e>=phi, or normalized d>=phi.
- Set r=0 and cnt=63.
REQ-015 When err is flagged, NORM SHALL go directly to END with product=0 and valid=0.
REQ-016 MULT SHALL run one iteration of MSB-first interleaved modular multiplication per cycle, for cnt=63 down to 0:
- t = 2r; if t>=phi, t = t-phi.
- If d_norm[cnt]==1: t = t+e; if t>=phi, t = t-phi.
- r = t.
REQ-017 Intermediate values SHALL use 65-bit width, so 2r and t+e never overflow. r SHALL stay below phi at all times.
REQ-018 On the iteration with cnt==0, the block SHALL register the result, assert done and move to END:
- product = r.
- valid = (r==1).
REQ-019 Latency SHALL be fixed:
- done is registered on the 66th edge after the edge that samples start_compute (1 NORM + 64 MULT + 1).
- On an error, done is registered on the 2nd edge.
REQ-020 END SHALL hold done=1 while start_compute=1. It SHALL return to IDLE on the first edge that samples start_compute=0, and done SHALL deassert on that edge.
REQ-021 product, valid and err SHALL hold their values in END and IDLE until the next accepted start.
REQ-022 Deasserting start_compute during NORM or MULT SHALL be ignored. The computation completes, and done is high for exactly one cycle.
REQ-023 Input changes after acceptance SHALL have no effect on the current computation.

Configuration
REQ-024 Macro MODINV_CHECK_SIGNED_D_EN SHALL select how d is interpreted:
- Defined: d is two's complement. If d[63]==1, d_norm = d+phi (mod 2^64), computed once in NORM; otherwise d_norm = d.
- Undefined: d is unsigned, d_norm = d, and any d>=phi sets err.

Reset
REQ-025 While reset_n=0, the block SHALL asynchronously enter IDLE and clear all outputs and internal registers:
- product=0, valid=0, err=0, busy=0, done=0.
- r=0, cnt=0.
REQ-026 Reset asserted mid-operation SHALL abort the computation with no residual state. After reset_n rises, the first edge with start_compute=1 starts a fresh computation.

Verification
REQ-027 The bench SHALL cover e=17, phi=3120, d=2753:
- Required: product=1, valid=1, err=0.
- done rises on the 66th edge after start is sampled.
- busy is high for 65 cycles.
REQ-028 The bench SHALL cover e=17, phi=3120, d=2752:
- Required: product=3104, valid=0, err=0.
REQ-029 The bench SHALL cover d=-367 (0xFFFF_FFFF_FFFF_FE91) with e=17, phi=3120:
- With MODINV_CHECK_SIGNED_D_EN defined: product=1, valid=1.
- With the macro undefined: err=1, product=0, and done on the 2nd edge.
REQ-030 The bench SHALL cover e=3120, phi=3120, d=1:
- Required: err=1, valid=0, product=0, busy=0 after edge 2, and done on the 2nd edge.
REQ-031 The bench SHALL cover reset_n pulsed low at MULT cycle 30, then a restart with e=17, phi=3120, d=2753:
- During reset all outputs read 0.
- The restart gives product=1 after 66 edges.
REQ-032 The bench SHALL cover the handshake:
- Hold start_compute high for 10 cycles after done: done stays high and product is stable.
- Drop start_compute: done=0 on the next edge.
- Re-raise start_compute: a new run is accepted.

Source files
------------

// File: rtl/modinv_check.sv
// modinv_check: checks a candidate modular inverse by computing (e*d) mod phi
// with a 64-step MSB-first interleaved modular multiplier.
// Optional feature: define MODINV_CHECK_SIGNED_D_EN to treat d as two's
// complement. A negative d is folded into range by adding phi once in NORM.
module modinv_check (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_compute,
    input  logic [63:0] e,
    input  logic [63:0] phi,
    input  logic [63:0] d,
    output logic [63:0] product,
    output logic        valid,
    output logic        err,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, NORM, MULT, END} state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] e_q;
    logic [63:0] phi_q;
    logic [63:0] d_q;
    logic [63:0] r;
    logic [5:0]  cnt;
    logic [63:0] d_norm;
    logic        range_err;
    logic [64:0] phi_w;
    logic [64:0] t_dbl;
    logic [64:0] t_red;
    logic [64:0] t_add;
    logic [64:0] t_fin;

    // Normalize the latched d and check that all operands lie inside [0, phi).
    always_comb begin
`ifdef MODINV_CHECK_SIGNED_D_EN
        d_norm = d_q[63] ? (d_q + phi_q) : d_q;
`else
        d_norm = d_q;
`endif
        range_err = (phi_q < 64'd2) || (e_q >= phi_q) || (d_norm >= phi_q);
    end

    // One interleaved step: r*2 reduced, then conditionally add e and reduce.
    // Both reductions need only one subtraction because r and e are below phi.
    always_comb begin
        phi_w = {1'b0, phi_q};
        t_dbl = {r, 1'b0};
        t_red = (t_dbl >= phi_w) ? (t_dbl - phi_w) : t_dbl;
        t_add = t_red + {1'b0, e_q};
        t_fin = t_red;
        if (d_q[cnt]) begin
            t_fin = (t_add >= phi_w) ? (t_add - phi_w) : t_add;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the busy flag derived from the current state.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start_compute) begin
                    next_state = NORM;
                end
            end
            NORM: begin
                busy       = 1'b1;
                next_state = range_err ? END : MULT;
            end
            MULT: begin
                busy = 1'b1;
                if (cnt == 6'd0) begin
                    next_state = END;
                end
            end
            END: begin
                if (!start_compute) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration registers and held results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q     <= 64'd0;
            phi_q   <= 64'd0;
            d_q     <= 64'd0;
            r       <= 64'd0;
            cnt     <= 6'd0;
            product <= 64'd0;
            valid   <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_compute) begin
                        e_q     <= e;
                        phi_q   <= phi;
                        d_q     <= d;
                        product <= 64'd0;
                        valid   <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                NORM: begin
                    d_q <= d_norm;
                    r   <= 64'd0;
                    cnt <= 6'd63;
                    if (range_err) begin
                        err     <= 1'b1;
                        product <= 64'd0;
                        valid   <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                MULT: begin
                    r   <= t_fin[63:0];
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd0) begin
                        product <= t_fin[63:0];
                        valid   <= (t_fin == 65'd1);
                        done    <= 1'b1;
                    end
                end
                END: begin
                    if (!start_compute) begin
                        done <= 1'b0;
                    end
                end
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_check.sv
// tb_modinv_check: directed testbench for modinv_check.
// Expectations for d = -367 follow MODINV_CHECK_SIGNED_D_EN when it is defined.
module tb_modinv_check;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_compute;
    logic [63:0] e;
    logic [63:0] phi;
    logic [63:0] d;
    logic [63:0] product;
    logic        valid;
    logic        err;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    modinv_check dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_compute (start_compute),
        .e             (e),
        .phi           (phi),
        .d             (d),
        .product       (product),
        .valid         (valid),
        .err           (err),
        .busy          (busy),
        .done          (done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [63:0] ei, input logic [63:0] pi, input logic [63:0] di);
        e             = ei;
        phi           = pi;
        d             = di;
        start_compute = 1'b1;
    endtask

    // Advances edges, numbering the start-sampling edge as 1, and records the
    // first edge after which done is high and how many samples showed busy.
    task automatic run_wait(input int max_edges, output int done_edge, output int busy_cnt);
        done_edge = 0;
        busy_cnt  = 0;
        for (int k = 1; k <= max_edges; k++) begin
            tick();
            if (busy) busy_cnt++;
            if (done && done_edge == 0) done_edge = k;
        end
    endtask

    task automatic finish_op();
        start_compute = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n       = 1'b1;
        start_compute = 1'b0;
        e             = 64'd0;
        phi           = 64'd0;
        d             = 64'd0;
        #2 reset_n = 1'b0;
        #20;
        checks++; if (product !== 64'd0) begin errors++; $display("[TB] FAIL rst_product: got %0d required 0", product); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b required 0", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b required 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b required 0", done); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_inverse();
        int de, bc;
        start_op(64'd17, 64'd3120, 64'd2753);
        run_wait(70, de, bc);
        checks++; if (de != 66) begin errors++; $display("[TB] FAIL inv_done_edge: got %0d required 66", de); end
        checks++; if (bc != 65) begin errors++; $display("[TB] FAIL inv_busy_cycles: got %0d required 65", bc); end
        checks++; if (product !== 64'd1) begin errors++; $display("[TB] FAIL inv_product: got %0d required 1", product); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL inv_valid: got %b required 1", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL inv_err: got %b required 0", err); end
        finish_op();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL inv_done_drop: got %b required 0", done); end
        checks++; if (product !== 64'd1 || valid !== 1'b1) begin errors++; $display("[TB] FAIL inv_hold_idle: got product %0d valid %b required 1 1", product, valid); end
    endtask

    task automatic test_not_inverse();
        int de, bc;
        start_op(64'd17, 64'd3120, 64'd2752);
        run_wait(70, de, bc);
        checks++; if (de != 66) begin errors++; $display("[TB] FAIL ninv_done_edge: got %0d required 66", de); end
        checks++; if (product !== 64'd3104) begin errors++; $display("[TB] FAIL ninv_product: got %0d required 3104", product); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL ninv_valid: got %b required 0", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ninv_err: got %b required 0", err); end
        finish_op();
    endtask

    task automatic test_signed_d();
        int de, bc;
        start_op(64'd17, 64'd3120, 64'hFFFF_FFFF_FFFF_FE91);
        run_wait(70, de, bc);
`ifdef MODINV_CHECK_SIGNED_D_EN
        checks++; if (de != 66) begin errors++; $display("[TB] FAIL sgn_done_edge: got %0d required 66", de); end
        checks++; if (product !== 64'd1) begin errors++; $display("[TB] FAIL sgn_product: got %0d required 1", product); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL sgn_valid: got %b required 1", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL sgn_err: got %b required 0", err); end
`else
        checks++; if (de != 2) begin errors++; $display("[TB] FAIL sgn_done_edge: got %0d required 2", de); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL sgn_err: got %b required 1", err); end
        checks++; if (product !== 64'd0) begin errors++; $display("[TB] FAIL sgn_product: got %0d required 0", product); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL sgn_valid: got %b required 0", valid); end
`endif
        finish_op();
    endtask

    task automatic test_err_range();
        int de, bc;
        start_op(64'd3120, 64'd3120, 64'd1);
        run_wait(5, de, bc);
        checks++; if (de != 2) begin errors++; $display("[TB] FAIL rng_done_edge: got %0d required 2", de); end
        checks++; if (bc != 1) begin errors++; $display("[TB] FAIL rng_busy_cycles: got %0d required 1", bc); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL rng_err: got %b required 1", err); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rng_valid: got %b required 0", valid); end
        checks++; if (product !== 64'd0) begin errors++; $display("[TB] FAIL rng_product: got %0d required 0", product); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rng_busy: got %b required 0", busy); end
        finish_op();
    endtask

    task automatic test_reset_mid();
        int de, bc;
        start_op(64'd17, 64'd3120, 64'd2753);
        repeat (32) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b required 1", busy); end
        reset_n = 1'b0;
        #2;
        checks++; if (product !== 64'd0 || valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_rst_outputs: got product %0d valid %b err %b busy %b done %b required all 0", product, valid, err, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_wait(70, de, bc);
        checks++; if (de != 66) begin errors++; $display("[TB] FAIL mid_done_edge: got %0d required 66", de); end
        checks++; if (product !== 64'd1 || valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_product: got product %0d valid %b required 1 1", product, valid); end
        finish_op();
    endtask

    task automatic test_input_change();
        int de, dcnt;
        start_op(64'd17, 64'd3120, 64'd2753);
        de   = 0;
        dcnt = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 3) begin
                e             = 64'd5;
                phi           = 64'd7;
                d             = 64'd3;
                start_compute = 1'b0;
            end
            if (done) begin
                dcnt++;
                if (de == 0) de = k;
            end
        end
        checks++; if (de != 66) begin errors++; $display("[TB] FAIL chg_done_edge: got %0d required 66", de); end
        checks++; if (dcnt != 1) begin errors++; $display("[TB] FAIL chg_done_cycles: got %0d required 1", dcnt); end
        checks++; if (product !== 64'd1 || valid !== 1'b1) begin errors++; $display("[TB] FAIL chg_product: got product %0d valid %b required 1 1", product, valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL chg_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_handshake();
        int de, bc, bad;
        start_op(64'd17, 64'd3120, 64'd2752);
        run_wait(70, de, bc);
        checks++; if (de != 66) begin errors++; $display("[TB] FAIL hs_done_edge: got %0d required 66", de); end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done !== 1'b1 || product !== 64'd3104) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL hs_hold: got %0d bad cycles (done %b product %0d) required 0", bad, done, product); end
        start_compute = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL hs_done_drop: got %b required 0", done); end
        start_op(64'd17, 64'd3120, 64'd2753);
        run_wait(70, de, bc);
        checks++; if (de != 66) begin errors++; $display("[TB] FAIL hs_rerun_edge: got %0d required 66", de); end
        checks++; if (product !== 64'd1) begin errors++; $display("[TB] FAIL hs_rerun_product: got %0d required 1", product); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_inverse();
        test_not_inverse();
        test_signed_d();
        test_err_range();
        test_reset_mid();
        test_input_change();
        test_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
